// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU: fetch FSM states, next-PC
// select codes, the halt opcode and instruction field bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int JIDX_MSB = 25;
    localparam int JIDX_LSB = 0;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch with a
// sign-extended word offset, and region jump keeping the top nibble of PC+4.
// Kept free of state so a pipelined fetch can reuse it unchanged.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] CurPC,
    input  logic [31:0]       IR,
    input  logic [1:0]        PCSrc,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              unused_opc;

    assign pc4     = CurPC + ADDR_W'(4);
    // Branch offset is always sign-extended, regardless of the datapath ExtSel.
    assign br_off  = {{(ADDR_W-16){IR[IMM_MSB]}}, IR[IMM_MSB:IMM_LSB]} << 2;
    assign br_tgt  = pc4 + br_off;
    assign jmp_tgt = {pc4[ADDR_W-1:28], IR[JIDX_MSB:JIDX_LSB], 2'b00};

    // The opcode bits play no part in target calculation.
    assign unused_opc = ^IR[OPC_MSB:OPC_LSB];

    // Select the target; the reserved code falls back to PC+4.
    always_comb begin
        next_pc = pc4;
        case (PCSrc)
            PCSRC_BR:  next_pc = br_tgt;
            PCSRC_JMP: next_pc = jmp_tgt;
            default:   next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch unit: owns PC and IR, runs BOOT/FETCH/EXEC/HALT with a
// req/ack handshake to instruction memory that tolerates wait states, and
// presents the decoded instruction fields to the control unit.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWre,
    input  logic [1:0]        PCSrc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] CurPC,
    output logic [5:0]        OpCode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       immediate,
    output logic              halted,
    output logic [31:0]       retired
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       retired_q, retired_d;
    logic              halted_q, halted_d;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .CurPC   (pc_q),
        .IR      (ir_q),
        .PCSrc   (PCSrc),
        .next_pc (next_pc)
    );

    // Next-state and handshake outputs; PCWre/PCSrc only matter in EXEC.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        halted_d    = halted_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                retired_d   = retired_q + 32'd1;
                if (PCWre) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end else begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign CurPC     = pc_q;
    assign OpCode    = ir_q[OPC_MSB:OPC_LSB];
    assign rs        = ir_q[RS_MSB:RS_LSB];
    assign rt        = ir_q[RT_MSB:RT_LSB];
    assign rd        = ir_q[RD_MSB:RD_LSB];
    assign immediate = ir_q[IMM_MSB:IMM_LSB];
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected fetch
// addresses and executed-instruction records; a negedge monitor pops them.
module tb_instr_fetch_unit;

    typedef struct {
        logic [36:0] fields;   // {OpCode, rs, rt, rd, immediate}
        logic [31:0] pc;
        logic [31:0] ret;
    } exec_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        PCWre = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, CurPC, retired;
    logic [5:0]  OpCode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] immediate;

    logic        rst_j = 1'b0;
    logic        pcwre_j = 1'b0;
    logic [1:0]  pcsrc_j = 2'b00;
    logic        ack_j = 1'b0;
    logic [31:0] rdata_j = 32'h0;
    logic        req_j, valid_j, halted_j;
    logic [31:0] addr_j, curpc_j, retired_j;
    logic [5:0]  opc_j;
    logic [4:0]  rs_j, rt_j, rd_j;
    logic [15:0] imm_j;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    exec_t       exec_q[$];
    logic [31:0] fetch_q[$];
    logic        prev_req = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ret = 32'h0;
    logic        m_halted = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .CLK(clk), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .instr_valid(instr_valid), .CurPC(CurPC),
        .OpCode(OpCode), .rs(rs), .rt(rt), .rd(rd), .immediate(immediate),
        .halted(halted), .retired(retired)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h2000_0020)) u_dut_j (
        .CLK(clk), .Reset(rst_j), .PCWre(pcwre_j), .PCSrc(pcsrc_j),
        .imem_req(req_j), .imem_addr(addr_j), .imem_rdata(rdata_j),
        .imem_ack(ack_j), .instr_valid(valid_j), .CurPC(curpc_j),
        .OpCode(opc_j), .rs(rs_j), .rt(rt_j), .rd(rd_j), .immediate(imm_j),
        .halted(halted_j), .retired(retired_j)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch/execute one instruction on the main DUT, starting in FETCH.
    task automatic run_instr(input logic [31:0] word, input int waits, input logic wre,
                             input logic [1:0] src, input logic [31:0] exp_next);
        exec_t e;
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            tick();
            check("wait_addr", imem_addr, m_pc);
            check("wait_valid", instr_valid, 1'b0);
        end
        e.fields = {word[31:26], word[25:21], word[20:16], word[15:11], word[15:0]};
        e.pc     = m_pc;
        e.ret    = m_ret;
        exec_q.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = word;
        PCWre      = wre;
        PCSrc      = src;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        m_ret++;
        if (wre) begin
            m_pc = exp_next;
            fetch_q.push_back(exp_next);
        end else begin
            m_halted = 1'b1;
        end
        tick();
        imem_ack = 1'b0;
        PCWre    = 1'b0;
        PCSrc    = 2'b10;
        check("retired", retired, m_ret);
        check("halted", halted, m_halted);
        check("curpc", CurPC, m_pc);
        check("valid_one_cycle", instr_valid, 1'b0);
    endtask

    // Jump-region checks on the second DUT, which boots at 0x2000_0020.
    task automatic run_jump(input logic [1:0] src, input logic [31:0] exp);
        rst_j = 1'b0;
        tick();
        check("j_reset_pc", curpc_j, 32'h2000_0020);
        rst_j = 1'b1;
        tick();
        check("j_fetch_req", req_j, 1'b1);
        ack_j   = 1'b1;
        rdata_j = 32'h0800_0040;
        pcwre_j = 1'b1;
        pcsrc_j = src;
        tick();
        check("j_exec_valid", valid_j, 1'b1);
        ack_j = 1'b0;
        tick();
        check("j_next_addr", addr_j, exp);
        check("j_next_req", req_j, 1'b1);
        pcwre_j = 1'b0;
    endtask

    // Monitor: compare executed instructions and each new fetch address.
    always @(negedge clk) begin
        exec_t e;
        logic [31:0] a;
        if (instr_valid === 1'b1) begin
            if (exec_q.size() == 0) begin
                check("exec_unexpected", 64'd1, 64'd0);
            end else begin
                e = exec_q.pop_front();
                check("exec_fields", {OpCode, rs, rt, rd, immediate}, e.fields);
                check("exec_pc", CurPC, e.pc);
                check("exec_retired", retired, e.ret);
            end
        end
        if (imem_req === 1'b1 && prev_req !== 1'b1) begin
            if (fetch_q.size() == 0) begin
                check("fetch_unexpected", 64'd1, 64'd0);
            end else begin
                a = fetch_q.pop_front();
                check("fetch_addr", imem_addr, a);
            end
        end
        prev_req = imem_req;
    end

    initial begin
        // Reset held with a live ack and all-ones data.
        Reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req", imem_req, 1'b0);
            check("rst_pc", CurPC, 32'h0);
            check("rst_opcode", OpCode, 6'h0);
            check("rst_retired", retired, 32'h0);
            check("rst_valid", instr_valid, 1'b0);
            check("rst_halted", halted, 1'b0);
        end
        Reset    = 1'b1;
        imem_ack = 1'b0;
        fetch_q.push_back(32'h0);
        tick();
        check("boot_req", imem_req, 1'b1);
        check("boot_addr", imem_addr, 32'h0);

        // Sequential runs, branches back and forward, reserved PCSrc.
        run_instr(32'h0022_0801, 0, 1'b1, 2'b00, 32'h0000_0004);
        run_instr(32'h0000_0000, 1, 1'b1, 2'b00, 32'h0000_0008);
        run_instr(32'h0443_1000, 0, 1'b1, 2'b00, 32'h0000_000C);
        run_instr(32'h0000_0000, 0, 1'b1, 2'b00, 32'h0000_0010);
        run_instr(32'h1022_FFFE, 0, 1'b1, 2'b01, 32'h0000_000C);
        run_instr(32'h0000_0000, 2, 1'b1, 2'b00, 32'h0000_0010);
        run_instr(32'h1022_0003, 0, 1'b1, 2'b01, 32'h0000_0020);
        run_instr(32'h0800_0040, 0, 1'b1, 2'b11, 32'h0000_0024);

        // Jump and reserved select in the 0x2xxx_xxxx region.
        rst_j = 1'b1;
        run_jump(2'b10, 32'h2000_0100);
        run_jump(2'b11, 32'h2000_0024);

        // Wait states, then reset in the same cycle as the ack.
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b0;
            tick();
            check("ws_addr", imem_addr, 32'h0000_0024);
            check("ws_valid", instr_valid, 1'b0);
            check("ws_req", imem_req, 1'b1);
        end
        Reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        check("rstack_opcode", OpCode, 6'h0);
        check("rstack_imm", immediate, 16'h0);
        check("rstack_pc", CurPC, 32'h0);
        check("rstack_req", imem_req, 1'b0);
        check("rstack_valid", instr_valid, 1'b0);
        check("rstack_retired", retired, 32'h0);
        Reset    = 1'b1;
        imem_ack = 1'b0;
        m_pc     = 32'h0;
        m_ret    = 32'h0;
        fetch_q.push_back(32'h0);
        tick();
        check("restart_req", imem_req, 1'b1);

        // Halt instruction, then a long idle with ack asserted.
        run_instr(32'hFC00_0000, 1, 1'b0, 2'b00, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0022_0801;
        PCWre      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("halt_req", imem_req, 1'b0);
            check("halt_pc", CurPC, 32'h0);
            check("halt_flag", halted, 1'b1);
            check("halt_retired", retired, 32'h1);
        end
        Reset    = 1'b0;
        imem_ack = 1'b0;
        PCWre    = 1'b0;
        tick();
        check("unhalt_flag", halted, 1'b0);
        check("unhalt_retired", retired, 32'h0);
        Reset    = 1'b1;
        m_pc     = 32'h0;
        m_ret    = 32'h0;
        m_halted = 1'b0;
        fetch_q.push_back(32'h0);
        tick();
        check("refetch_req", imem_req, 1'b1);
        check("refetch_addr", imem_addr, 32'h0);
        run_instr(32'h0022_0801, 0, 1'b1, 2'b00, 32'h0000_0004);

        tick();
        tick();
        check("exec_q_drained", exec_q.size(), 0);
        check("fetch_q_drained", fetch_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
